// File: rtl/neo_zmc2_sched_pkg.sv
// Shared types and constants for the ZMC2 fetch scheduler.
package neo_zmc2_sched_pkg;

  localparam int unsigned SLOT_LOAD  = 14;
  localparam int unsigned SLOT_W     = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned CR_W       = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [CR_W-1:0] cr;
    logic            flip;
  } cr_entry_t;

endpackage

// File: rtl/zmc2_cr_fifo.sv
// Two-entry CR word FIFO; head reads as zero when empty, push+pop may coincide.
module zmc2_cr_fifo
  import neo_zmc2_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  cr_entry_t        push_data,
  input  logic             pop,
  output cr_entry_t        head_c,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next_c
);

  cr_entry_t        mem_q [FIFO_DEPTH];
  logic             do_pop;
  logic [CNT_W-1:0] wr_pos;
  logic             wr_en;

  assign do_pop = pop && (count != '0);
  assign head_c = (count != '0) ? mem_q[0] : '0;
  // After a pop the tail slot shifts down, so the write lands one position lower.
  assign wr_pos = do_pop ? count - CNT_W'(1) : count;
  assign wr_en  = push && (wr_pos != CNT_W'(FIFO_DEPTH));

  always_comb begin
    count_next_c = count;
    if (push && !do_pop && (count != CNT_W'(FIFO_DEPTH))) begin
      count_next_c = count + CNT_W'(1);
    end else if (!push && do_pop) begin
      count_next_c = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count <= count_next_c;
      if (do_pop) begin
        mem_q[0] <= mem_q[1];
      end
      if (wr_en) begin
        mem_q[wr_pos[0]] <= push_data;
      end
    end
  end

endmodule

// File: rtl/neo_zmc2_sched.sv
// ZMC2 fetch scheduler: fetches CR word pairs from ROM and issues one load per 16 enables.
// Optional NEO_ZMC2_UNDERRUN_CNT_EN adds a saturating UNDERRUN_CNT output.
module neo_zmc2_sched
  import neo_zmc2_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = 21
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLK_EN_12M,
  input  logic              RUN,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic              REQ_FLIP,
  output logic              ROM_REQ,
  output logic [ADDR_W:0]   ROM_ADDR,
  input  logic              ROM_ACK,
  input  logic [CR_W-1:0]   ROM_DATA,
  output logic [CR_W-1:0]   CR,
  output logic              LOAD,
  output logic              H,
  output logic              EVEN,
`ifdef NEO_ZMC2_UNDERRUN_CNT_EN
  output logic [7:0]        UNDERRUN_CNT,
`endif
  output logic              UNDERRUN
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              flip_q, flip_d;
  logic              half_d;
  logic              req_ready_d;
  logic              rom_req_d;
  logic [ADDR_W:0]   rom_addr_d;
  logic              ack_c;
  logic              pop_c;
  logic [SLOT_W-1:0] slot_q;
  cr_entry_t         push_data_c;
  cr_entry_t         head_c;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fifo_count_next_c;

  assign ack_c       = ROM_REQ && ROM_ACK;
  assign pop_c       = CLK_EN_12M && RUN && (slot_q == SLOT_W'(SLOT_LOAD));
  assign push_data_c = '{cr: ROM_DATA, flip: flip_q};

  zmc2_cr_fifo u_fifo (
    .clk          (CLK),
    .reset        (RESET),
    .push         (ack_c),
    .push_data    (push_data_c),
    .pop          (pop_c),
    .head_c       (head_c),
    .count        (fifo_count),
    .count_next_c (fifo_count_next_c)
  );

  // Fetch FSM state and registered ROM/request handshake outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      flip_q    <= 1'b0;
      REQ_READY <= 1'b0;
      ROM_REQ   <= 1'b0;
      ROM_ADDR  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      flip_q    <= flip_d;
      REQ_READY <= req_ready_d;
      ROM_REQ   <= rom_req_d;
      ROM_ADDR  <= rom_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    flip_d     = flip_q;
    rom_req_d  = 1'b0;
    rom_addr_d = ROM_ADDR;
    unique case (state_q)
      IDLE: begin
        if (REQ_READY && REQ_VALID) begin
          state_d = FETCH0;
          addr_d  = REQ_ADDR;
          flip_d  = REQ_FLIP;
        end
      end
      FETCH0:  if (ack_c) state_d = FETCH1;
      FETCH1:  if (ack_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    half_d      = (state_d == FETCH1) ? ~flip_d : flip_d;
    // An outstanding request is held until acked; a new one needs FIFO room after this cycle.
    if (ROM_REQ && !ROM_ACK) begin
      rom_req_d = 1'b1;
    end else if ((state_d != IDLE) && (fifo_count_next_c < CNT_W'(FIFO_DEPTH))) begin
      rom_req_d  = 1'b1;
      rom_addr_d = {addr_d, half_d};
    end
  end

  // Slot timer and load sequencing toward the shifter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      slot_q   <= '0;
      LOAD     <= 1'b0;
      EVEN     <= 1'b0;
      CR       <= '0;
      H        <= 1'b0;
      UNDERRUN <= 1'b0;
    end else if (!RUN) begin
      slot_q <= '0;
      LOAD   <= 1'b0;
      EVEN   <= 1'b0;
    end else begin
      EVEN <= slot_q[0];
      if (CLK_EN_12M) begin
        slot_q <= slot_q + SLOT_W'(1);
        LOAD   <= pop_c;
        if (pop_c) begin
          CR <= head_c.cr;
          H  <= head_c.flip;
          if (fifo_count == '0) begin
            UNDERRUN <= 1'b1;
          end
        end
      end
    end
  end

`ifdef NEO_ZMC2_UNDERRUN_CNT_EN
  // Saturating count of load slots that found the FIFO empty.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      UNDERRUN_CNT <= '0;
    end else if (pop_c && (fifo_count == '0) && (UNDERRUN_CNT != 8'hFF)) begin
      UNDERRUN_CNT <= UNDERRUN_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_neo_zmc2_sched.sv
// Randomized bench for neo_zmc2_sched against a queue-based transaction model.
module tb_neo_zmc2_sched;

  localparam int unsigned ADDR_W = 21;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic              en        = 1'b0;
  logic              run       = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr  = '0;
  logic              req_flip  = 1'b0;
  logic              rom_req;
  logic [ADDR_W:0]   rom_addr;
  logic              rom_ack   = 1'b0;
  logic [31:0]       rom_data  = '0;
  logic [31:0]       cr;
  logic              load;
  logic              h_out;
  logic              even;
  logic              underrun;
`ifdef NEO_ZMC2_UNDERRUN_CNT_EN
  logic [7:0]        underrun_cnt;
`endif

  neo_zmc2_sched #(.ADDR_W(ADDR_W)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .CLK_EN_12M (en),
    .RUN        (run),
    .REQ_VALID  (req_valid),
    .REQ_READY  (req_ready),
    .REQ_ADDR   (req_addr),
    .REQ_FLIP   (req_flip),
    .ROM_REQ    (rom_req),
    .ROM_ADDR   (rom_addr),
    .ROM_ACK    (rom_ack),
    .ROM_DATA   (rom_data),
    .CR         (cr),
    .LOAD       (load),
    .H          (h_out),
    .EVEN       (even),
`ifdef NEO_ZMC2_UNDERRUN_CNT_EN
    .UNDERRUN_CNT (underrun_cnt),
`endif
    .UNDERRUN   (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [ADDR_W:0] addr; logic flip; } half_t;
  typedef struct packed { logic [31:0] cr; logic h; } word_t;

  // Reference model: outstanding ROM halves, buffered words, slot position, expected outputs.
  half_t       pend[$];
  word_t       fifo_m[$];
  int unsigned slot_m    = 0;
  int unsigned exp_cnt   = 0;
  logic        exp_req   = 1'b0;
  logic        exp_ready = 1'b0;
  logic        exp_load  = 1'b0;
  logic        exp_h     = 1'b0;
  logic        exp_even  = 1'b0;
  logic        exp_under = 1'b0;
  logic [31:0] exp_cr    = '0;
  logic        addr_zero = 1'b1;
  logic        prev_rst  = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("rom_req",   32'(rom_req),   32'(exp_req));
    check_eq("load",      32'(load),      32'(exp_load));
    check_eq("cr",        cr,             exp_cr);
    check_eq("h",         32'(h_out),     32'(exp_h));
    check_eq("even",      32'(even),      32'(exp_even));
    check_eq("underrun",  32'(underrun),  32'(exp_under));
    if (addr_zero) check_eq("rom_addr_rst", 32'(rom_addr), 32'd0);
`ifdef NEO_ZMC2_UNDERRUN_CNT_EN
    check_eq("underrun_cnt", 32'(underrun_cnt), 32'(exp_cnt));
`endif
  endtask

  // Advance the model across the coming clock edge using the inputs just driven.
  task automatic model_step();
    word_t w;
    half_t hf;
    logic  ack_ok;
    if (rst) begin
      pend.delete();
      fifo_m.delete();
      slot_m    = 0;
      exp_cnt   = 0;
      exp_req   = 1'b0;
      exp_ready = 1'b0;
      exp_load  = 1'b0;
      exp_h     = 1'b0;
      exp_even  = 1'b0;
      exp_under = 1'b0;
      exp_cr    = '0;
      addr_zero = 1'b1;
      return;
    end
    ack_ok = rom_ack && exp_req;
    if (run && en) begin
      if (slot_m == 14) begin
        if (fifo_m.size() > 0) begin
          w = fifo_m.pop_front();
        end else begin
          w = '0;
          exp_under = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end
        exp_cr   = w.cr;
        exp_h    = w.h;
        exp_load = 1'b1;
      end else begin
        exp_load = 1'b0;
      end
    end
    if (!run) exp_load = 1'b0;
    exp_even = run ? ((slot_m % 2) == 1) : 1'b0;
    slot_m   = !run ? 0 : (en ? (slot_m + 1) % 16 : slot_m);
    if (ack_ok && pend.size() > 0) begin
      hf = pend.pop_front();
      check_eq("rom_addr", 32'(rom_addr), 32'(hf.addr));
      w.cr = rom_data;
      w.h  = hf.flip;
      fifo_m.push_back(w);
    end
    if (exp_ready && req_valid) begin
      hf.addr = {req_addr, req_flip};
      hf.flip = req_flip;
      pend.push_back(hf);
      hf.addr = {req_addr, ~req_flip};
      pend.push_back(hf);
    end
    exp_req   = (exp_req && !rom_ack) || (pend.size() > 0 && fifo_m.size() < 2);
    exp_ready = (pend.size() == 0);
    if (exp_req) addr_zero = 1'b0;
  endtask

  // Probabilities in percent, except p_rst in tenths of a percent.
  task automatic run_phase(input int unsigned cycles, input int unsigned p_en,
                           input int unsigned p_req, input int unsigned p_ack,
                           input int unsigned p_rst, input bit allow_blank);
    for (int unsigned c = 0; c < cycles; c++) begin
      @(negedge clk);
      check_outputs();
      prev_rst = rst;
      rst      = ($urandom_range(999) < p_rst);
      if (!allow_blank) run = 1'b1;
      else if ($urandom_range(99) < 1) run = ~run;
      en        = ($urandom_range(99) < p_en);
      req_valid = ($urandom_range(99) < p_req);
      req_addr  = ADDR_W'($urandom);
      req_flip  = 1'($urandom);
      if (prev_rst && !rst) rom_ack = 1'b1;
      else if (rom_req)     rom_ack = ($urandom_range(99) < p_ack);
      else                  rom_ack = ($urandom_range(99) < 5);
      rom_data = $urandom;
      model_step();
    end
  endtask

  initial begin
    run_phase(4,    0,   0,  0,   1000, 1'b0);
    run_phase(6000, 50,  30, 40,  2,    1'b1);
    run_phase(3000, 100, 40, 100, 1,    1'b1);
    run_phase(4400, 100, 0,  50,  0,    1'b0);
    run_phase(1000, 30,  30, 40,  0,    1'b1);
    @(negedge clk);
    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/neo_zmc2_sched.md
# neo_zmc2_sched

Fetch scheduler and sequencer for the ZMC2 sprite-dot shifter. Accepts sprite tile-line requests, fetches the two 32-bit CR words per line from sprite ROM through a request/acknowledge port, and buffers them in a 2-entry FIFO. It drives the `CR`/`LOAD`/`H`/`EVEN` inputs of `neo_zmc2` on the 12 MHz enable grid: one 8-pixel load every 16 enables. It sits between the line-buffer/sprite-list logic and `neo_zmc2`.

## Interface
Parameters:
- `ADDR_W`, 21, width of tile-line address `REQ_ADDR`; `ROM_ADDR` is `ADDR_W+1` bits.

Ports:
- `CLK`  in  1  system clock; single clock domain.
- `RESET`  in  1  synchronous, active-high reset.
- `CLK_EN_12M`  in  1  12 MHz clock enable; all slot timing advances only on it.
- `RUN`  in  1  active-display window; slot timer runs only while high.
- `REQ_VALID`  in  1  tile-line request valid.
- `REQ_READY`  out  1  scheduler accepts the request this cycle.
- `REQ_ADDR`  in  ADDR_W  tile-line ROM address (word pair base).
- `REQ_FLIP`  in  1  horizontal flip for this line.
- `ROM_REQ`  out  1  ROM read request; held until ack.
- `ROM_ADDR`  out  ADDR_W+1  `{addr, half}`; stable while `ROM_REQ`.
- `ROM_ACK`  in  1  one-cycle ack; `ROM_DATA` valid the same cycle.
- `ROM_DATA`  in  32  CR word.
- `CR`  out  32  to `neo_zmc2`.
- `LOAD`  out  1  to `neo_zmc2`.
- `H`  out  1  to `neo_zmc2`.
- `EVEN`  out  1  to `neo_zmc2`.
- `UNDERRUN`  out  1  sticky: a load slot found the FIFO empty.

## Operation
- Fetch FSM has 3 states: `IDLE`, `FETCH0`, `FETCH1`.
  - `IDLE`: `REQ_READY=1`. On `REQ_VALID`, latch addr/flip and go to `FETCH0`.
  - `FETCH0`: first half. Half index is 0, or 1 if flip.
  - `FETCH1`: the other half. On ack, return to `IDLE`.
- In `FETCHx`, `ROM_REQ` asserts only when the FIFO count is less than 2. Once asserted, it stays high until `ROM_ACK`, even if a pop occurs.
- On `ROM_ACK` with `ROM_REQ=1`: push `{ROM_DATA, flip}` to the FIFO.
- `ROM_ACK` while `ROM_REQ=0` is ignored.
- Slot timer: 4-bit `SLOT`.
  - Increments on each `CLK_EN_12M` while `RUN`, wrapping 15→0.
  - `RUN=0` forces `SLOT=0`, `LOAD=0`, `EVEN=0`. The FIFO and fetch FSM keep running, so prefetch occurs during blanking.
- `EVEN` = registered `SLOT[0]`.
- Load slot is the enable with `SLOT==14`:
  - Pop the FIFO head into `CR`/`H` and set `LOAD=1`.
  - If the FIFO is empty, set `CR=0` (transparent), `H=0`, `LOAD=1`, and `UNDERRUN=1`.
- `LOAD` clears on the next enable (`SLOT==15`). It therefore spans exactly one 12 MHz period.
- Push and pop in the same cycle: count unchanged, and the pushed word lands behind the head.
- `UNDERRUN` clears only on `RESET`.

## Timing
- Reset values:
  - outputs: `CR=0`, `H=0`, `LOAD=0`, `EVEN=0`, `ROM_REQ=0`, `ROM_ADDR=0`, `UNDERRUN=0`, `REQ_READY=0`.
  - internal: FSM `IDLE`, FIFO empty, `SLOT=0`.
- `REQ_READY` goes high the first cycle after `RESET` deasserts.
- Request accept → `ROM_REQ` high: next cycle, if the FIFO has room.
- ROM ack → FIFO entry visible: next cycle.
- Back-to-back acks are accepted every cycle.
- `RUN` rising: first `LOAD` is on the 15th enable after `RUN` rises (`SLOT` 0→14).
- `RESET` mid-transaction drops `ROM_REQ` immediately. A late `ROM_ACK` after reset is ignored.
- All outputs are registered.

## Configuration
- `NEO_ZMC2_UNDERRUN_CNT_EN` defined: adds output `UNDERRUN_CNT[7:0]`.
  - Saturating count of empty load slots, reset to 0.
  - Saturates at 255.
- Not defined: port absent, no counter logic; `UNDERRUN` flag still present.

## Structure
- Package `neo_zmc2_sched_pkg` holds:
  - FSM state enum
  - `SLOT_LOAD=14`
  - `FIFO_DEPTH=2`
  - FIFO entry typedef `{cr[31:0], flip}`
- Sub-module `zmc2_cr_fifo`: 2-entry FIFO with push/pop/count. Simultaneous push+pop is legal, including when full, and pop on empty returns 0.

## Test plan
- Reset, one request addr `0x00010`, flip=0, ack data `0x11111111` then `0x22222222`, `RUN=1`:
  - `ROM_ADDR` sequence is `0x00020`, `0x00021`.
  - First `LOAD` has `CR=0x11111111`, `H=0`.
  - 16 enables later, `CR=0x22222222`.
- Same request with flip=1: `ROM_ADDR` `0x00021` then `0x00020`, and `H=1` on both loads.
- `RUN=1` with no requests:
  - `LOAD` every 16 enables with `CR=0`.
  - `UNDERRUN=1` after the first load.
  - With the macro, `UNDERRUN_CNT` reaches 255 and holds.
- FIFO full (2 words), next request pending: `ROM_REQ` stays low until the load slot pops, then rises the following cycle.
- Push on the same cycle as the load-slot pop with count=2: count stays 2, and order is preserved across the next two loads.
- Assert `RESET` while `ROM_REQ=1`, then pulse `ROM_ACK` one cycle after reset: FIFO stays empty, and all outputs hold reset values.
